// File: rtl/kernel_bc_sync_pkg.sv
// kernel_bc_sync_pkg: shared FSM state type, default depth and clog2 helper for the start-token sync block
package kernel_bc_sync_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, START = 1'b1} state_e;
    localparam int MAX_INFLIGHT_DEF = 4;
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction
endpackage

// File: rtl/kernel_bc_start_sync_tag_fifo.sv
// kernel_bc_start_sync_tag_fifo: shift-register tag FIFO, head at slot 0, pointer marks the next free slot
// Ports: clk, reset (sync, active-high); push/din write a tag; pop drops the head; head is the oldest tag.
// No full/empty flags: the parent never pushes when full nor pops when empty.
module kernel_bc_start_sync_tag_fifo
    import kernel_bc_sync_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = MAX_INFLIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int PW = clog2(DEPTH + 1);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         ptr_q, ptr_d, widx;
    always_comb begin
        ptr_d = ptr_q + PW'(push) - PW'(pop);
        // on a simultaneous pop the queue shifts down first, so the new tag lands one slot lower
        widx = ptr_q - PW'(pop);
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
            mem_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) if (push && widx == PW'(i)) mem_d[i] = din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            mem_q <= mem_d;
        end
    end
    assign head = mem_q[0];
endmodule

// File: rtl/kernel_bc_start_token_sync.sv
// kernel_bc_start_token_sync: pops start tokens, drives a child ap_start/ap_done handshake, forwards done tokens in issue order
// Ports: clk, reset (sync, active-high); tok_empty_n/tok_read/tok_dout start FIFO read side;
// child_ap_start/ready/done/continue child handshake; done_full_n/done_write/done_din done FIFO write side;
// inflight started-but-not-done count; sync_idle idle flag.
// Optional KERNEL_BC_START_SYNC_PERF_EN adds saturating perf_starts and perf_stall counters.
module kernel_bc_start_token_sync
    import kernel_bc_sync_pkg::*;
#(
    parameter int DATA_WIDTH   = 1,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tok_empty_n,
    output logic                  tok_read,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic                  child_ap_start,
    input  logic                  child_ap_ready,
    input  logic                  child_ap_done,
    output logic                  child_ap_continue,
    input  logic                  done_full_n,
    output logic                  done_write,
    output logic [DATA_WIDTH-1:0] done_din,
    output logic [CNT_WIDTH-1:0]  inflight,
    output logic                  sync_idle
`ifdef KERNEL_BC_START_SYNC_PERF_EN
    ,
    output logic [31:0]           perf_starts,
    output logic [31:0]           perf_stall
`endif
);
    if (CNT_WIDTH != clog2(MAX_INFLIGHT + 1)) begin : g_bad_cnt_width
        $error("CNT_WIDTH must equal clog2(MAX_INFLIGHT+1)");
    end
    state_e                state_q, state_d;
    logic                  start_q;
    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head;
    // handshake strobes are masked by reset so nothing is popped or pushed in a reset cycle
    always_comb begin
        tok_read          = !reset && state_q == IDLE && tok_empty_n && inflight_q < CNT_WIDTH'(MAX_INFLIGHT);
        done_write        = !reset && child_ap_done && done_full_n && inflight_q != '0;
        child_ap_continue = done_write;
        done_din          = inflight_q != '0 ? head : '0;
        inflight_d        = inflight_q + CNT_WIDTH'(tok_read) - CNT_WIDTH'(done_write);
        state_d           = tok_read ? START : (state_q == START && child_ap_ready) ? IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            start_q    <= 1'b0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= state_d == START;
            inflight_q <= inflight_d;
        end
    end
    assign child_ap_start = start_q;
    assign inflight       = inflight_q;
    assign sync_idle      = state_q == IDLE && inflight_q == '0;
    kernel_bc_start_sync_tag_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (MAX_INFLIGHT)
    ) u_tags (
        .clk  (clk),
        .reset(reset),
        .push (tok_read),
        .pop  (done_write),
        .din  (tok_dout),
        .head (head)
    );
`ifdef KERNEL_BC_START_SYNC_PERF_EN
    logic [31:0] starts_q, stall_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            starts_q <= '0;
            stall_q  <= '0;
        end else begin
            starts_q <= starts_q + 32'(tok_read && starts_q != '1);
            stall_q  <= stall_q + 32'(child_ap_done && !done_full_n && stall_q != '1);
        end
    end
    assign perf_starts = starts_q;
    assign perf_stall  = stall_q;
`endif
endmodule

// File: tb/tb_kernel_bc_start_token_sync.sv
// tb_kernel_bc_start_token_sync: table vectors, corner sequences and random traffic against a queue-based model
module tb_kernel_bc_start_token_sync;
    logic       clk = 1'b0;
    logic       reset, tok_empty_n, tok_read, child_ap_start, child_ap_ready, child_ap_done;
    logic       child_ap_continue, done_full_n, done_write, sync_idle;
    logic [0:0] tok_dout, done_din;
    logic [2:0] inflight;
`ifdef KERNEL_BC_START_SYNC_PERF_EN
    logic [31:0] perf_starts, perf_stall;
`endif
    kernel_bc_start_token_sync dut (
        .clk              (clk),
        .reset            (reset),
        .tok_empty_n      (tok_empty_n),
        .tok_read         (tok_read),
        .tok_dout         (tok_dout),
        .child_ap_start   (child_ap_start),
        .child_ap_ready   (child_ap_ready),
        .child_ap_done    (child_ap_done),
        .child_ap_continue(child_ap_continue),
        .done_full_n      (done_full_n),
        .done_write       (done_write),
        .done_din         (done_din),
        .inflight         (inflight),
        .sync_idle        (sync_idle)
`ifdef KERNEL_BC_START_SYNC_PERF_EN
        ,
        .perf_starts      (perf_starts),
        .perf_stall       (perf_stall)
`endif
    );
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit m_start;
    bit mq[$];
    logic obs_tr, obs_st, obs_dw, obs_cont, obs_din, obs_idle;
    int   obs_inf;

    typedef struct {
        bit e, d, rdy, dn, fn;
        bit tr, st, dw, din;
        int inf;
        bit idle;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // one clock: apply inputs after the falling edge, compare against the model, advance the model
    task automatic cyc(input bit r, input bit e, input bit d, input bit rdy, input bit dn, input bit fn);
        bit exp_tr, exp_dw;
        reset = r; tok_empty_n = e; tok_dout = d; child_ap_ready = rdy; child_ap_done = dn; done_full_n = fn;
        #1;
        exp_tr = !r && !m_start && e && mq.size() < 4;
        exp_dw = !r && dn && fn && mq.size() > 0;
        obs_tr = tok_read; obs_st = child_ap_start; obs_dw = done_write; obs_cont = child_ap_continue;
        obs_din = done_din; obs_idle = sync_idle; obs_inf = int'(inflight);
        chk("tok_read", obs_tr, exp_tr);
        chk("done_write", obs_dw, exp_dw);
        chk("ap_continue", obs_cont, exp_dw);
        chk("ap_start", obs_st, m_start);
        chk("inflight", obs_inf, mq.size());
        chk("sync_idle", obs_idle, !m_start && mq.size() == 0);
        if (!r) chk("done_din", obs_din, mq.size() > 0 ? mq[0] : 0);
        if (r) begin
            mq.delete();
            m_start = 0;
        end else begin
            if (exp_dw) void'(mq.pop_front());
            if (exp_tr) begin
                mq.push_back(d);
                m_start = 1;
            end else if (m_start && rdy) m_start = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int left, cnt;
        // single token, then simultaneous pop/push at inflight==1 with tags 0 then 1
        tv[0]  = '{1,1,0,0,1, 1,0,0,0, 0,1};
        tv[1]  = '{0,0,0,0,1, 0,1,0,1, 1,0};
        tv[2]  = '{0,0,1,0,1, 0,1,0,1, 1,0};
        tv[3]  = '{0,0,0,0,1, 0,0,0,1, 1,0};
        tv[4]  = '{0,0,0,0,1, 0,0,0,1, 1,0};
        tv[5]  = '{0,0,0,0,1, 0,0,0,1, 1,0};
        tv[6]  = '{0,0,0,0,1, 0,0,0,1, 1,0};
        tv[7]  = '{0,0,0,1,1, 0,0,1,1, 1,0};
        tv[8]  = '{0,0,0,0,1, 0,0,0,0, 0,1};
        tv[9]  = '{1,0,0,0,1, 1,0,0,0, 0,1};
        tv[10] = '{0,0,1,0,1, 0,1,0,0, 1,0};
        tv[11] = '{0,0,0,0,1, 0,0,0,0, 1,0};
        tv[12] = '{1,1,0,1,1, 1,0,1,0, 1,0};
        tv[13] = '{0,0,1,0,1, 0,1,0,1, 1,0};
        tv[14] = '{0,0,0,1,1, 0,0,1,1, 1,0};
        tv[15] = '{0,0,0,0,1, 0,0,0,0, 0,1};
        reset = 1; tok_empty_n = 0; tok_dout = 0; child_ap_ready = 0; child_ap_done = 0; done_full_n = 1;
        m_start = 0;
        repeat (2) @(negedge clk);
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_start", obs_st, 0);
        chk("reset_inflight", obs_inf, 0);
        chk("reset_idle", obs_idle, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(0, tv[i].e, tv[i].d, tv[i].rdy, tv[i].dn, tv[i].fn);
            chk($sformatf("vec%0d_tok_read", i), obs_tr, tv[i].tr);
            chk($sformatf("vec%0d_ap_start", i), obs_st, tv[i].st);
            chk($sformatf("vec%0d_done_write", i), obs_dw, tv[i].dw);
            chk($sformatf("vec%0d_done_din", i), obs_din, tv[i].din);
            chk($sformatf("vec%0d_inflight", i), obs_inf, tv[i].inf);
            chk($sformatf("vec%0d_sync_idle", i), obs_idle, tv[i].idle);
        end
        // full: six tokens queued, child always ready, never done
        left = 6; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, left > 0, 1'($urandom), 1, 0, 1);
            if (obs_tr) begin
                left--;
                cnt++;
            end
        end
        chk("full_pops", cnt, 4);
        chk("full_inflight", obs_inf, 4);
        chk("full_no_read", obs_tr, 0);
        // backpressure: done held while downstream full, then released
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            cnt += int'(obs_cont);
        end
        chk("bp_continue_cnt", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, cnt == 0, 1);
            cnt += int'(obs_dw);
        end
        chk("bp_pushes", cnt, 1);
        chk("bp_inflight", obs_inf, 3);
        // reset with inflight==3 while in START
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        chk("rst_mid_start", obs_st, 0);
        chk("rst_mid_inflight", obs_inf, 0);
        chk("rst_mid_idle", obs_idle, 1);
        chk("rst_mid_done_write", obs_dw, 0);
        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 3) != 0);
`ifdef KERNEL_BC_START_SYNC_PERF_EN
        cyc(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1'(k), 0, 0, 1);
            cyc(0, 0, 0, 1, 0, 1);
        end
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 0);
        chk("perf_starts", int'(perf_starts), 3);
        chk("perf_stall", int'(perf_stall), 7);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kernel_bc_start_token_sync.md
Name: kernel_bc_start_token_sync

Overview:
- Consumer-side controller for a dataflow start-token channel.
- Pops 1-bit-wide (generally DATA_WIDTH) start tokens from the read side of a start FIFO, drives the ap_start/ap_ready/ap_done/ap_continue handshake of one child process (e.g. write_back), and forwards each completion as a done token into a downstream FIFO write side.
- Tags are returned in issue order.
- Sits between a start FIFO and the next dataflow stage.

Parameters:
- DATA_WIDTH, 1, token/tag width.
- MAX_INFLIGHT, 4, maximum started-but-not-done invocations; power of two, 2..16.
- CNT_WIDTH, 3, inflight counter width; must equal clog2(MAX_INFLIGHT+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- tok_empty_n  in  1  start FIFO holds a token.
- tok_read  out  1  pop start FIFO; combinational.
- tok_dout  in  DATA_WIDTH  start token tag.
- child_ap_start  out  1  child start request; registered.
- child_ap_ready  in  1  child accepted start.
- child_ap_done  in  1  child finished one invocation; held until ap_continue.
- child_ap_continue  out  1  done acknowledge; combinational.
- done_full_n  in  1  downstream FIFO has space.
- done_write  out  1  push done token; combinational.
- done_din  out  DATA_WIDTH  tag of the oldest in-flight invocation.
- inflight  out  CNT_WIDTH  current in-flight count; registered.
- sync_idle  out  1  high when the FSM is IDLE and inflight==0.

Behaviour:
- Reset (synchronous, active-high, clk domain): state=IDLE, child_ap_start=0, inflight=0, tag FIFO empty, sync_idle=1. Combinational outputs tok_read, child_ap_continue and done_write evaluate to 0. done_din is 0 when the tag FIFO is empty.
- Reset asserted mid-operation:
  - Drop all state and tags.
  - No pop or push occurs in the reset cycle.
  - Child re-initialisation is the system's responsibility.
- FSM states: IDLE, START.
- IDLE:
  - tok_read = tok_empty_n & (inflight < MAX_INFLIGHT).
  - When tok_read=1, tok_dout is pushed into the tag FIFO, inflight increments, and the next state is START.
- START:
  - child_ap_start=1, held level.
  - When child_ap_ready=1 in the same cycle, child_ap_start clears on the next edge and the state returns to IDLE.
  - No pop occurs while in START, so the minimum spacing between pops is 2 cycles.
- Completion path, independent of the FSM:
  - done_write = child_ap_done & done_full_n & (inflight != 0).
  - child_ap_continue = done_write.
  - done_din = tag FIFO head.
  - On done_write, pop the tag FIFO and decrement inflight.
- Backpressure: when done_full_n=0, child_ap_continue stays 0 and the child holds ap_done; no token is lost.
- Simultaneous pop and push in one cycle: inflight is unchanged, and the tag FIFO shifts and reads correctly. When inflight==1, the head is the old tag, not the new one.
- Full: when inflight==MAX_INFLIGHT, tok_read=0 even if tok_empty_n=1.
- Spurious child_ap_done while inflight==0: ignored, no push.
- Counter arithmetic is CNT_WIDTH unsigned and never wraps, guaranteed by the gating above.

Optional Feature:
- Macro: KERNEL_BC_START_SYNC_PERF_EN.
- When defined, add outputs perf_starts (32 bits) and perf_stall (32 bits), both registered and cleared by reset.
  - perf_starts counts tok_read pulses.
  - perf_stall counts cycles with child_ap_done=1 and done_full_n=0.
  - Both counters saturate at all-ones.
- When undefined, these ports and all associated logic are absent.

Decomposition:
- Shared package kernel_bc_sync_pkg contains:
  - FSM state typedef {IDLE, START}.
  - Constant for the default MAX_INFLIGHT.
  - Function clog2 for CNT_WIDTH checking.
- Sub-module kernel_bc_start_sync_tag_fifo: DATA_WIDTH x MAX_INFLIGHT tag FIFO.
  - Shift-register storage with an address pointer.
  - Push and pop ports, with simultaneous push and pop allowed.
  - Head output.
  - No full/empty flags; the parent's inflight counter is authoritative.

Test Plan:
- Single token:
  - Stimulus: tok_dout=1, tok_empty_n=1 for 1 cycle; child_ap_ready pulses 2 cycles later; child_ap_done 5 cycles after that; done_full_n=1.
  - Required: tok_read=1 for exactly one cycle; child_ap_start high for 2 cycles; done_write=1 with done_din=1 for one cycle; inflight goes 0->1->0; sync_idle=1 at the end.
- Full:
  - Stimulus: 6 tokens queued, child_ap_ready immediate, child_ap_done never asserted.
  - Required: exactly 4 pops; inflight=4; tok_read stays 0 thereafter.
- Backpressure:
  - Stimulus: child_ap_done=1 with done_full_n=0 for 10 cycles, then done_full_n=1.
  - Required: child_ap_continue=0 for those 10 cycles, then exactly one push.
- Simultaneous pop and push at inflight==1:
  - Stimulus: tags 0 then 1 (DATA_WIDTH=1).
  - Required: inflight stays 1; done_din=0 during the push; the next done yields done_din=1.
- Reset mid-operation:
  - Stimulus: reset at inflight=3, in START.
  - Required: the next cycle shows child_ap_start=0, inflight=0, sync_idle=1, and no stale done_write.
- Macro build with KERNEL_BC_START_SYNC_PERF_EN:
  - Stimulus: 3 starts, and 7 cycles with ap_done held while done_full_n=0.
  - Required: perf_starts=3, perf_stall=7.
